// File: rtl/tx_mix_pkg.sv
// Shared types and arithmetic helpers for the TX NCO mixer.
package tx_mix_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PRIME = 2'd1,
    RUN   = 2'd2
  } mix_state_e;

  // Sign-extends p from in_w bits, rounds half up while dropping 'shift' LSBs,
  // then clamps to a signed ow-bit range; sat flags any clamp.
  function automatic logic signed [63:0] round_sat(
    input  logic signed [63:0] p,
    input  int unsigned        in_w,
    input  int unsigned        shift,
    input  int unsigned        ow,
    output logic               sat
  );
    logic signed [63:0] pe;
    logic signed [63:0] r;
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    pe  = (p <<< (64 - in_w)) >>> (64 - in_w);
    r   = (pe + (64'sd1 <<< (shift - 1))) >>> shift;
    hi  = (64'sd1 <<< (ow - 1)) - 64'sd1;
    lo  = -(64'sd1 <<< (ow - 1));
    sat = 1'b0;
    if (r > hi) begin
      r   = hi;
      sat = 1'b1;
    end else if (r < lo) begin
      r   = lo;
      sat = 1'b1;
    end
    return r;
  endfunction

endpackage

// File: rtl/tx_mix_fifo.sv
// Small circular baseband FIFO with occupancy count and synchronous flush.
module tx_mix_fifo #(
  parameter int DW    = 16,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic                       flush,
  input  logic                       push,
  input  logic                       pop,
  input  logic [DW-1:0]              wr_data,
  output logic [DW-1:0]              rd_data,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [DW-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;

  always_ff @(posedge clk) begin
    if (push && !flush) mem[wr_ptr] <= wr_data;
  end

  assign rd_data = mem[rd_ptr];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/tx_nco_mixer.sv
// Baseband x NCO sine mixer with priming FIFO, rounding and saturation.
// Optional macro TX_MIX_UNDERFLOW_CNT_EN adds a saturating underflow event counter.
module tx_nco_mixer
  import tx_mix_pkg::*;
#(
  parameter int MPR        = 12,
  parameter int DW         = 16,
  parameter int OW         = 16,
  parameter int FIFO_DEPTH = 4,
  parameter int PRIME_LVL  = 2
) (
  input  logic           clk,
  input  logic           reset_n,
  input  logic           clken,
  input  logic           tx_en_i,
  input  logic [MPR-1:0] nco_sin_i,
  input  logic           nco_valid_i,
  input  logic [DW-1:0]  bb_data_i,
  input  logic           bb_valid_i,
  output logic           bb_ready_o,
  output logic [OW-1:0]  mix_o,
  output logic           mix_valid_o,
  output logic           sat_o,
  output logic           underflow_o
`ifdef TX_MIX_UNDERFLOW_CNT_EN
  ,
  output logic [15:0]    underflow_cnt_o
`endif
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam int PW = DW + MPR;

  mix_state_e            state_q;
  mix_state_e            state_d;
  logic [CW-1:0]         fifo_count;
  logic [DW-1:0]         fifo_head;
  logic                  push;
  logic                  pop;
  logic                  flush;
  logic                  nco_acc;
  logic                  uf_evt;
  logic                  flag_clr;
  logic signed [DW-1:0]  mult;
  logic signed [MPR-1:0] sin_s;
  logic signed [PW-1:0]  p1_q;
  logic                  v1_q;
  logic                  v2_q;
  logic signed [OW-1:0]  mix_d;
  logic                  sat_d;

  // Ready looks only at the registered count, so a same-cycle pop never frees a slot.
  assign bb_ready_o = (state_q != IDLE) && (fifo_count < CW'(FIFO_DEPTH));
  assign push       = bb_valid_i && bb_ready_o && clken;
  assign nco_acc    = nco_valid_i && clken;
  assign pop        = nco_acc && (state_q == RUN) && (fifo_count != '0);
  assign uf_evt     = nco_acc && (state_q == RUN) && (fifo_count == '0);
  assign flush      = clken && ((state_q == IDLE) || !tx_en_i);
  assign flag_clr   = clken && (state_q == IDLE) && tx_en_i;
  assign sin_s      = nco_sin_i;
  assign mult       = pop ? fifo_head : '0;

  tx_mix_fifo #(
    .DW    (DW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .flush   (flush),
    .push    (push),
    .pop     (pop),
    .wr_data (bb_data_i),
    .rd_data (fifo_head),
    .count   (fifo_count)
  );

  always_comb begin
    state_d = state_q;
    if (!tx_en_i) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE:    state_d = PRIME;
        PRIME:   if (fifo_count >= CW'(PRIME_LVL)) state_d = RUN;
        RUN:     state_d = RUN;
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)   state_q <= IDLE;
    else if (clken) state_q <= state_d;
  end

  always_comb begin
    sat_d = 1'b0;
    mix_d = OW'(round_sat({{(64-PW){1'b0}}, p1_q}, PW, MPR - 1, OW, sat_d));
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      p1_q  <= '0;
      v1_q  <= 1'b0;
      v2_q  <= 1'b0;
      mix_o <= '0;
      sat_o <= 1'b0;
    end else if (clken) begin
      v1_q <= nco_acc;
      if (nco_acc) p1_q <= PW'(mult) * PW'(sin_s);
      v2_q <= v1_q;
      if (v1_q) mix_o <= mix_d;
      if (flag_clr)           sat_o <= 1'b0;
      else if (v1_q && sat_d) sat_o <= 1'b1;
    end
  end

  assign mix_valid_o = v2_q && clken;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)         underflow_o <= 1'b0;
    else if (flag_clr)    underflow_o <= 1'b0;
    else if (uf_evt)      underflow_o <= 1'b1;
  end

`ifdef TX_MIX_UNDERFLOW_CNT_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)                          underflow_cnt_o <= '0;
    else if (flag_clr)                     underflow_cnt_o <= '0;
    else if (uf_evt && underflow_cnt_o != '1) underflow_cnt_o <= underflow_cnt_o + 16'd1;
  end
`endif

endmodule

// File: tb/tb_tx_nco_mixer.sv
// Directed self-checking bench for tx_nco_mixer with hand-computed expectations.
module tb_tx_nco_mixer;
  import tx_mix_pkg::*;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        clken;
  logic        tx_en_i;
  logic [11:0] nco_sin_i;
  logic        nco_valid_i;
  logic [15:0] bb_data_i;
  logic        bb_valid_i;
  logic        bb_ready_o;
  logic [15:0] mix_o;
  logic        mix_valid_o;
  logic        sat_o;
  logic        underflow_o;
`ifdef TX_MIX_UNDERFLOW_CNT_EN
  logic [15:0] underflow_cnt_o;
`endif

  int n_checks = 0;
  int n_errors = 0;

  tx_nco_mixer #(
    .MPR        (12),
    .DW         (16),
    .OW         (16),
    .FIFO_DEPTH (4),
    .PRIME_LVL  (2)
  ) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .clken       (clken),
    .tx_en_i     (tx_en_i),
    .nco_sin_i   (nco_sin_i),
    .nco_valid_i (nco_valid_i),
    .bb_data_i   (bb_data_i),
    .bb_valid_i  (bb_valid_i),
    .bb_ready_o  (bb_ready_o),
    .mix_o       (mix_o),
    .mix_valid_o (mix_valid_o),
    .sat_o       (sat_o),
    .underflow_o (underflow_o)
`ifdef TX_MIX_UNDERFLOW_CNT_EN
    ,
    .underflow_cnt_o (underflow_cnt_o)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, $signed(act), $signed(exp));
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_out(input string tag, input logic vld, input int val);
    check({tag, "_vld"}, 32'(mix_valid_o), 32'(vld));
    check({tag, "_mix"}, 32'($signed(mix_o)), 32'(val));
  endtask

  int exp4 [4] = '{100, 150, 200, 250};

  initial begin
    reset_n = 1'b0; clken = 1'b1; tx_en_i = 1'b0;
    nco_sin_i = '0; nco_valid_i = 1'b0; bb_data_i = '0; bb_valid_i = 1'b0;
    repeat (2) step();
    check_out("rst", 1'b0, 0);
    check("rst_sat", 32'(sat_o), 32'(0));
    check("rst_uf", 32'(underflow_o), 32'(0));
    check("rst_rdy", 32'(bb_ready_o), 32'(0));
    reset_n = 1'b1;
    step();
    check("idle_rdy", 32'(bb_ready_o), 32'(0));

    // 1: prime with two 0x4000 samples, mix with 2047
    tx_en_i = 1'b1;
    step();
    check("prime_rdy", 32'(bb_ready_o), 32'(1));
    bb_valid_i = 1'b1; bb_data_i = 16'h4000;
    step();
    step();
    bb_valid_i = 1'b0;
    check("prime_state", 32'(dut.state_q), 32'(PRIME));
    step();
    check("run_state", 32'(dut.state_q), 32'(RUN));
    nco_valid_i = 1'b1; nco_sin_i = 12'd2047;
    step();
    nco_valid_i = 1'b0;
    check("t1_lat", 32'(mix_valid_o), 32'(0));
    step();
    check_out("t1", 1'b1, 16376);
    check("t1_sat", 32'(sat_o), 32'(0));
    step();
    check_out("t1_hold", 1'b0, 16376);

    // 2: 0x4000 x -2048, then -32768 x -2048 clamps
    bb_valid_i = 1'b1; bb_data_i = 16'h8000;
    step();
    bb_valid_i = 1'b0;
    nco_valid_i = 1'b1; nco_sin_i = 12'h800;
    step();
    step();
    nco_valid_i = 1'b0;
    check_out("t2a", 1'b1, -16384);
    check("t2a_sat", 32'(sat_o), 32'(0));
    step();
    check_out("t2b", 1'b1, 32767);
    check("t2b_sat", 32'(sat_o), 32'(1));
    step();
    check("t2_sat_sticky", 32'(sat_o), 32'(1));

    // 3: underflow with empty FIFO for 3 NCO samples
    nco_valid_i = 1'b1; nco_sin_i = 12'd1000;
    step();
    check("t3_uf", 32'(underflow_o), 32'(1));
    step();
    check_out("t3_0", 1'b1, 0);
    step();
    nco_valid_i = 1'b0;
    check_out("t3_1", 1'b1, 0);
    step();
    check_out("t3_2", 1'b1, 0);
`ifdef TX_MIX_UNDERFLOW_CNT_EN
    check("t3_cnt", 32'(underflow_cnt_o), 32'(3));
`endif

    // 4: fill to full, then a blocked push alongside a pop
    bb_valid_i = 1'b1; nco_sin_i = 12'd1024;
    for (int i = 1; i <= 4; i++) begin
      bb_data_i = 16'(i * 100);
      step();
    end
    check("t4_full_cnt", 32'(dut.fifo_count), 32'(4));
    check("t4_full_rdy", 32'(bb_ready_o), 32'(0));
    bb_data_i = 16'd500; nco_valid_i = 1'b1;
    step();
    nco_valid_i = 1'b0;
    check("t4_after_pop_cnt", 32'(dut.fifo_count), 32'(3));
    step();
    bb_valid_i = 1'b0;
    check_out("t4_first", 1'b1, 50);
    check("t4_refill_cnt", 32'(dut.fifo_count), 32'(4));
    nco_valid_i = 1'b1;
    step();
    check("t4_gap", 32'(mix_valid_o), 32'(0));
    for (int i = 0; i < 4; i++) begin
      step();
      check_out("t4_seq", 1'b1, exp4[i]);
      if (i == 2) nco_valid_i = 1'b0;
    end
    check("t4_empty", 32'(dut.fifo_count), 32'(0));

    // 5: tx_en dropped with two products in flight
    bb_valid_i = 1'b1; bb_data_i = 16'd1000;
    step();
    bb_data_i = 16'd2000;
    step();
    bb_valid_i = 1'b0;
    nco_valid_i = 1'b1;
    step();
    tx_en_i = 1'b0;
    step();
    nco_valid_i = 1'b0;
    check_out("t5_0", 1'b1, 500);
    check("t5_state", 32'(dut.state_q), 32'(IDLE));
    step();
    check_out("t5_1", 1'b1, 1000);
    check("t5_cnt", 32'(dut.fifo_count), 32'(0));
    check("t5_rdy", 32'(bb_ready_o), 32'(0));
    step();
    check("t5_done", 32'(mix_valid_o), 32'(0));

    // 6: re-enable clears flags; freeze with clken low mid-stream
    tx_en_i = 1'b1;
    step();
    check("t6_sat_clr", 32'(sat_o), 32'(0));
    check("t6_uf_clr", 32'(underflow_o), 32'(0));
`ifdef TX_MIX_UNDERFLOW_CNT_EN
    check("t6_cnt_clr", 32'(underflow_cnt_o), 32'(0));
`endif
    bb_valid_i = 1'b1; bb_data_i = 16'd600;
    step();
    bb_data_i = 16'd800;
    step();
    bb_valid_i = 1'b0;
    step();
    nco_valid_i = 1'b1;
    step();
    step();
    check_out("t6_pre", 1'b1, 300);
    clken = 1'b0; bb_valid_i = 1'b1; bb_data_i = 16'd123;
    for (int i = 0; i < 5; i++) begin
      step();
      check_out("t6_frz", 1'b0, 300);
      check("t6_frz_cnt", 32'(dut.fifo_count), 32'(0));
      check("t6_frz_state", 32'(dut.state_q), 32'(RUN));
    end
    check("t6_frz_uf", 32'(underflow_o), 32'(0));
    clken = 1'b1; nco_valid_i = 1'b0; bb_valid_i = 1'b0;
    #1;
    check_out("t6_resume", 1'b1, 300);
    step();
    check_out("t6_next", 1'b1, 400);
    step();
    check("t6_end_vld", 32'(mix_valid_o), 32'(0));
    check("t6_end_cnt", 32'(dut.fifo_count), 32'(0));
    check("t6_end_uf", 32'(underflow_o), 32'(0));

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end

endmodule
